// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and hands {instr, pc, pc+4} to decode.
// Optional build macro MISALIGN_TRAP_EN: a misaligned redirect traps into FAULT instead of being word-aligned.
module fetch_unit #(
    parameter int unsigned          WIDTH    = 32,
    parameter logic [WIDTH-1:0]     RESET_PC = WIDTH'(32'hBFC0_0000)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_target,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic [WIDTH-1:0] instr_pc_plus4,
    output logic             fetch_fault
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_e;
`else
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             kill_q, kill_d;
    logic             instr_valid_q, instr_valid_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [WIDTH-1:0] instr_pc_plus4_q, instr_pc_plus4_d;
    logic [WIDTH-1:0] target_c;
    logic [WIDTH-1:0] pc_plus4_c;

    assign pc_plus4_c = pc_q + PC_STEP;

`ifdef MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    logic misaligned_c;

    assign target_c     = redirect_target;
    assign misaligned_c = |redirect_target[1:0];
    assign fetch_fault  = fault_q;
`else
    // Without the trap, targets are silently word-aligned.
    assign target_c     = redirect_target & ~WIDTH'(3);
    assign fetch_fault  = 1'b0;
`endif

    // Request channel is driven straight from state; held low while in reset.
    assign imem_req_valid = rst_n && (state_q == S_REQ);
    assign imem_addr      = pc_q;

    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_pc_plus4 = instr_pc_plus4_q;

    // Next-state: redirect outranks every other event in each state.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        kill_d           = kill_q;
        instr_valid_d    = instr_valid_q;
        instr_d          = instr_q;
        instr_pc_d       = instr_pc_q;
        instr_pc_plus4_d = instr_pc_plus4_q;
`ifdef MISALIGN_TRAP_EN
        fault_d          = fault_q;
`endif
        case (state_q)
            S_REQ: begin
                if (redirect) begin
                    pc_d = target_c;
                    if (imem_req_ready) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d = target_c;
                    if (imem_rsp_valid) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d          = imem_rdata;
                        instr_pc_d       = pc_q;
                        instr_pc_plus4_d = pc_plus4_c;
                        instr_valid_d    = 1'b1;
                        state_d          = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d          = target_c;
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end else if (instr_ready) begin
                    pc_d          = pc_plus4_c;
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end
            end
`ifdef MISALIGN_TRAP_EN
            S_FAULT: begin
                state_d = S_FAULT;
            end
`endif
            default: begin
                state_d = S_REQ;
            end
        endcase
`ifdef MISALIGN_TRAP_EN
        // A misaligned target is terminal; only reset leaves FAULT.
        if (redirect && misaligned_c && (state_q != S_FAULT)) begin
            state_d       = S_FAULT;
            fault_d       = 1'b1;
            pc_d          = pc_q;
            kill_d        = 1'b0;
            instr_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_REQ;
            pc_q             <= RESET_PC;
            kill_q           <= 1'b0;
            instr_valid_q    <= 1'b0;
            instr_q          <= '0;
            instr_pc_q       <= '0;
            instr_pc_plus4_q <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            kill_q           <= kill_d;
            instr_valid_q    <= instr_valid_d;
            instr_q          <= instr_d;
            instr_pc_q       <= instr_pc_d;
            instr_pc_plus4_q <= instr_pc_plus4_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle instruction memory model.
// Build with MISALIGN_TRAP_EN defined to exercise the trap variant of the misaligned-redirect scenario.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;
    bit auto_rsp = 1'b1;

    fetch_unit #(.WIDTH(32), .RESET_PC(32'hBFC0_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Advance one cycle; the memory answers one cycle after an accepted request.
    task automatic tick();
        logic        fire;
        logic [31:0] a;
        fire = imem_req_valid && imem_req_ready;
        a    = imem_addr;
        @(posedge clk);
        #1;
        if (auto_rsp) begin
            imem_rsp_valid = fire;
            imem_rdata     = fire ? word_of(a) : 32'h0;
        end
    endtask

    task automatic fetch_one(input logic [31:0] exp, input int hold);
        logic [31:0] nxt;
        nxt = exp + 32'd4;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL fetch req_valid got %b exp 1", imem_req_valid); end
        checks++; if (imem_addr !== exp) begin errors++; $display("FAIL fetch imem_addr got %h exp %h", imem_addr, exp); end
        instr_ready = (hold == 0);
        tick();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL fetch wait req_valid got %b exp 0", imem_req_valid); end
        tick();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL fetch instr_valid got %b exp 1", instr_valid); end
        checks++; if (instr_pc !== exp) begin errors++; $display("FAIL fetch instr_pc got %h exp %h", instr_pc, exp); end
        checks++; if (instr_pc_plus4 !== nxt) begin errors++; $display("FAIL fetch instr_pc_plus4 got %h exp %h", instr_pc_plus4, nxt); end
        checks++; if (instr !== word_of(exp)) begin errors++; $display("FAIL fetch instr got %h exp %h", instr, word_of(exp)); end
        for (int k = 0; k < hold; k++) begin
            tick();
            checks++; if (instr_valid !== 1'b1 || instr_pc !== exp || instr !== word_of(exp))
                begin errors++; $display("FAIL hold stable cyc %0d got v=%b pc=%h i=%h exp pc=%h", k, instr_valid, instr_pc, instr, exp); end
            checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL hold req_valid cyc %0d got %b exp 0", k, imem_req_valid); end
        end
        instr_ready = 1'b1;
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL consume instr_valid got %b exp 0", instr_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== nxt)
            begin errors++; $display("FAIL consume next req got v=%b a=%h exp 1 %h", imem_req_valid, imem_addr, nxt); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_target = 32'h0; instr_ready = 1'b1; auto_rsp = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset req_valid got %b exp 0", imem_req_valid); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset instr_valid got %b exp 0", instr_valid); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0 || instr_pc_plus4 !== 32'h0)
            begin errors++; $display("FAIL reset instr regs got %h %h %h exp 0", instr, instr_pc, instr_pc_plus4); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset fetch_fault got %b exp 0", fetch_fault); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL reset pc got %h exp bfc00000", imem_addr); end
    endtask

    task automatic test_sequential();
        fetch_one(32'hBFC0_0000, 0);
        fetch_one(32'hBFC0_0004, 0);
        fetch_one(32'hBFC0_0008, 0);
    endtask

    task automatic test_hold();
        fetch_one(32'hBFC0_000C, 5);
    endtask

    task automatic test_redirect_req();
        checks++; if (imem_addr !== 32'hBFC0_0010) begin errors++; $display("FAIL redir_req start addr got %h exp bfc00010", imem_addr); end
        imem_req_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h100;
        tick();
        redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0)
            begin errors++; $display("FAIL redir_req wait got iv=%b rv=%b exp 0 0", instr_valid, imem_req_valid); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_req stale dropped instr_valid got %b exp 0", instr_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100)
            begin errors++; $display("FAIL redir_req new addr got v=%b a=%h exp 1 100", imem_req_valid, imem_addr); end
        fetch_one(32'h100, 0);
    endtask

    task automatic test_redirect_hold();
        tick();
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h104)
            begin errors++; $display("FAIL redir_hold setup got v=%b pc=%h exp 1 104", instr_valid, instr_pc); end
        redirect = 1'b1; redirect_target = 32'h200; instr_ready = 1'b1;
        tick();
        redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_hold instr_valid got %b exp 0", instr_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200)
            begin errors++; $display("FAIL redir_hold addr got v=%b a=%h exp 1 200", imem_req_valid, imem_addr); end
    endtask

    task automatic test_wrap();
        imem_req_ready = 1'b0; redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC)
            begin errors++; $display("FAIL wrap redirect addr got v=%b a=%h exp 1 fffffffc", imem_req_valid, imem_addr); end
        imem_req_ready = 1'b1;
        fetch_one(32'hFFFF_FFFC, 0);
    endtask

    task automatic test_wait_redirect();
        auto_rsp = 1'b0; imem_rsp_valid = 1'b0;
        tick();
        redirect = 1'b1; redirect_target = 32'h300;
        tick();
        redirect = 1'b0;
        checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
            begin errors++; $display("FAIL wait_redir still waiting got rv=%b iv=%b exp 0 0", imem_req_valid, instr_valid); end
        imem_rsp_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wait_redir killed rsp instr_valid got %b exp 0", instr_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h300)
            begin errors++; $display("FAIL wait_redir addr got v=%b a=%h exp 1 300", imem_req_valid, imem_addr); end
        // Response outside WAIT must be ignored.
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_rsp_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h300)
            begin errors++; $display("FAIL stray rsp got iv=%b rv=%b a=%h exp 0 1 300", instr_valid, imem_req_valid, imem_addr); end
        auto_rsp = 1'b1; imem_req_ready = 1'b1;
        fetch_one(32'h300, 0);
        // Redirect coinciding with the response: word dropped, no kill left behind.
        tick();
        redirect = 1'b1; redirect_target = 32'h500;
        tick();
        redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h500)
            begin errors++; $display("FAIL wait_redir_rsp got iv=%b rv=%b a=%h exp 0 1 500", instr_valid, imem_req_valid, imem_addr); end
        fetch_one(32'h500, 0);
    endtask

    task automatic test_mid_reset();
        imem_req_ready = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
            begin errors++; $display("FAIL mid_reset outputs got rv=%b iv=%b exp 0 0", imem_req_valid, instr_valid); end
        #1;
        rst_n = 1'b1;
        auto_rsp = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rdata = 32'hCAFE_F00D;
        tick();
        imem_rsp_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'hBFC0_0000)
            begin errors++; $display("FAIL mid_reset late rsp got iv=%b rv=%b a=%h exp 0 1 bfc00000", instr_valid, imem_req_valid, imem_addr); end
        auto_rsp = 1'b1;
    endtask

    task automatic test_misalign();
        imem_req_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h102;
        tick();
        redirect = 1'b0;
`ifdef MISALIGN_TRAP_EN
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL misalign fetch_fault got %b exp 1", fetch_fault); end
        imem_req_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h400;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b1)
                begin errors++; $display("FAIL fault sticky cyc %0d got rv=%b iv=%b ff=%b exp 0 0 1", k, imem_req_valid, instr_valid, fetch_fault); end
        end
        redirect = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'hBFC0_0000)
            begin errors++; $display("FAIL fault reset exit got ff=%b rv=%b a=%h exp 0 1 bfc00000", fetch_fault, imem_req_valid, imem_addr); end
`else
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL misalign fetch_fault got %b exp 0", fetch_fault); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100)
            begin errors++; $display("FAIL misalign aligned addr got v=%b a=%h exp 1 100", imem_req_valid, imem_addr); end
        imem_req_ready = 1'b1;
        fetch_one(32'h100, 0);
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold();
        test_redirect_req();
        test_redirect_hold();
        test_wrap();
        test_wait_redirect();
        test_mid_reset();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
